// File: rtl/phy_mdio_init.sv
// phy_mdio_init: power-up sequencer for the RGMII Ethernet PHY.
// It holds the PHY in reset, waits for it to settle, then writes a fixed table of clause-22
// MDIO registers over a write-only bit-banged MDC/MDIO pair. It then raises phy_init_done.
//
// Ports:
//   clock          system clock, rising edge
//   resetn         synchronous active-low reset
//   restart        single-cycle pulse; reruns the whole sequence (honoured only in DONE)
//   phy_resetn     PHY hardware reset, active-low (registered)
//   mdio_scl       MDC (registered)
//   mdio_sda       MDIO data, always driven (registered)
//   phy_init_done  high once every table write has completed (registered)
module phy_mdio_init #(
    parameter int unsigned CLK_DIV           = 5,
    parameter int unsigned RESET_CYCLES      = 250000,
    parameter int unsigned POST_RESET_CYCLES = 250000,
    parameter logic [4:0]  PHY_ADDR          = 5'd0,
    parameter int unsigned NUM_WRITES        = 2,
    // Entry i is {regad[4:0], data[15:0]} at bits [21*i +: 21]
    parameter logic [(NUM_WRITES > 0 ? 21*NUM_WRITES : 21)-1:0] WRITE_TABLE =
        {5'h18, 16'hF1E7, 5'h1C, 16'h8C00}
) (
    input  logic clock,
    input  logic resetn,
    input  logic restart,
    output logic phy_resetn,
    output logic mdio_scl,
    output logic mdio_sda,
    output logic phy_init_done
);

    // The delay counter also times the inter-frame gap, so it must hold 2*CLK_DIV too.
    localparam int unsigned MaxDelay0 =
        (RESET_CYCLES > POST_RESET_CYCLES) ? RESET_CYCLES : POST_RESET_CYCLES;
    localparam int unsigned MaxDelay = (MaxDelay0 > 2*CLK_DIV) ? MaxDelay0 : 2*CLK_DIV;
    localparam int unsigned DW = $clog2(MaxDelay + 1);

    typedef enum logic [2:0] {StHold, StSettle, StFrame, StGap, StDone} state_e;

    state_e        state_q, state_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic [7:0]    phase_q, phase_d;
    logic [5:0]    bit_q, bit_d;
    logic [3:0]    idx_q, idx_d;
    logic          scl_q, scl_d;
    logic          sda_q, sda_d;
    logic          rstn_q, rstn_d;
    logic          done_q, done_d;

    logic [20:0]   entry;
    logic [63:0]   frame;
    logic [5:0]    bit_nxt;

    always_comb begin
        entry = '0;
        for (int i = 0; i < NUM_WRITES; i++) begin
            if (idx_q == i[3:0]) entry = WRITE_TABLE[21*i +: 21];
        end
    end

    assign frame   = {32'hFFFF_FFFF, 2'b01, 2'b01, PHY_ADDR, entry[20:16], 2'b10, entry[15:0]};
    assign bit_nxt = bit_q + 6'd1;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q <= StHold;
            cnt_q   <= '0;
            phase_q <= '0;
            bit_q   <= '0;
            idx_q   <= '0;
            scl_q   <= 1'b0;
            sda_q   <= 1'b1;
            rstn_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            idx_q   <= idx_d;
            scl_q   <= scl_d;
            sda_q   <= sda_d;
            rstn_q  <= rstn_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        idx_d   = idx_q;
        scl_d   = scl_q;
        sda_d   = sda_q;
        rstn_d  = rstn_q;
        done_d  = done_q;
        unique case (state_q)
            StHold: begin
                rstn_d = 1'b0;
                cnt_d  = cnt_q + DW'(1);
                if (cnt_q == DW'(RESET_CYCLES)) begin
                    state_d = StSettle;
                    cnt_d   = '0;
                    rstn_d  = 1'b1;
                end
            end
            StSettle: begin
                cnt_d = cnt_q + DW'(1);
                if (cnt_q == DW'(POST_RESET_CYCLES - 1)) begin
                    cnt_d = '0;
                    idx_d = '0;
                    if (NUM_WRITES == 0) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end else begin
                        state_d = StFrame;
                        phase_d = '0;
                        bit_d   = '0;
                        scl_d   = 1'b0;
                        sda_d   = 1'b1;  // first preamble bit
                    end
                end
            end
            StFrame: begin
                // Each half of a bit cell lasts CLK_DIV cycles; scl_q tells which half we are in.
                if (phase_q == 8'(CLK_DIV - 1)) begin
                    phase_d = '0;
                    if (!scl_q) begin
                        scl_d = 1'b1;
                    end else begin
                        scl_d = 1'b0;
                        if (bit_q == 6'd63) begin
                            state_d = StGap;
                            sda_d   = 1'b1;
                            cnt_d   = '0;
                        end else begin
                            bit_d = bit_nxt;
                            sda_d = frame[~bit_nxt];  // MSB-first: bit n is frame[63-n]
                        end
                    end
                end else begin
                    phase_d = phase_q + 8'd1;
                end
            end
            StGap: begin
                cnt_d = cnt_q + DW'(1);
                if (cnt_q == DW'(2*CLK_DIV - 1)) begin
                    cnt_d = '0;
                    idx_d = idx_q + 4'd1;
                    if (32'(idx_q) + 32'd1 < NUM_WRITES) begin
                        state_d = StFrame;
                        phase_d = '0;
                        bit_d   = '0;
                        sda_d   = 1'b1;
                    end else begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end
                end
            end
            StDone: begin
                if (restart) begin
                    state_d = StHold;
                    done_d  = 1'b0;
                    rstn_d  = 1'b0;
                    // The restart edge itself is the first held cycle, matching reset release.
                    cnt_d   = DW'(1);
                end
            end
            default: state_d = StHold;
        endcase
    end

    assign phy_resetn    = rstn_q;
    assign mdio_scl      = scl_q;
    assign mdio_sda      = sda_q;
    assign phy_init_done = done_q;

endmodule

// File: tb/tb_phy_mdio_init.sv
// Directed testbench for phy_mdio_init: reset release, frame capture, done timing,
// mid-frame reset, restart, and a NUM_WRITES=0 instance.
module tb_phy_mdio_init;

    localparam int unsigned CD  = 2;
    localparam int unsigned RC  = 10;
    localparam int unsigned PRC = 5;

    logic clock = 1'b0;
    logic resetn = 1'b0;
    logic restart = 1'b0;
    logic phy_resetn, mdio_scl, mdio_sda, phy_init_done;
    logic z_phy_resetn, z_scl, z_sda, z_done;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int e0 = 0;
    int base = 0;

    logic [63:0] f0_exp;
    logic [63:0] f1_exp;

    phy_mdio_init #(
        .CLK_DIV(CD), .RESET_CYCLES(RC), .POST_RESET_CYCLES(PRC), .PHY_ADDR(5'h01)
    ) dut (
        .clock(clock), .resetn(resetn), .restart(restart), .phy_resetn(phy_resetn),
        .mdio_scl(mdio_scl), .mdio_sda(mdio_sda), .phy_init_done(phy_init_done)
    );

    phy_mdio_init #(
        .CLK_DIV(CD), .RESET_CYCLES(RC), .POST_RESET_CYCLES(PRC), .PHY_ADDR(5'h01),
        .NUM_WRITES(0), .WRITE_TABLE(21'h0)
    ) dut_zero (
        .clock(clock), .resetn(resetn), .restart(restart), .phy_resetn(z_phy_resetn),
        .mdio_scl(z_scl), .mdio_sda(z_sda), .phy_init_done(z_done)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // MDIO monitor: records sda and edge number at each MDC rise
    logic scl_prev = 1'b0;
    logic z_scl_prev = 1'b0;
    int rise_cnt = 0;
    int z_rise_cnt = 0;
    logic rise_bit [1024];
    int rise_cyc [1024];

    always @(negedge clock) begin
        if (mdio_scl && !scl_prev) begin
            if (rise_cnt < 1024) begin
                rise_bit[rise_cnt] = mdio_sda;
                rise_cyc[rise_cnt] = cyc;
            end
            rise_cnt++;
        end
        scl_prev = mdio_scl;
        if (z_scl && !z_scl_prev) z_rise_cnt++;
        z_scl_prev = z_scl;
    end

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    function automatic logic [63:0] grab(int b);
        logic [63:0] w;
        for (int i = 0; i < 64; i++) w[63-i] = rise_bit[b+i];
        return w;
    endfunction

    task automatic test_reset();
        resetn = 1'b0;
        restart = 1'b0;
        repeat (3) tick();
        n_checks++;
        if ({phy_resetn, mdio_scl, mdio_sda, phy_init_done} !== 4'b0010) begin
            n_fail++;
            $display("FAIL reset_values: got %b want 0010",
                     {phy_resetn, mdio_scl, mdio_sda, phy_init_done});
        end
        n_checks++;
        if ({z_phy_resetn, z_scl, z_sda, z_done} !== 4'b0010) begin
            n_fail++;
            $display("FAIL reset_values_zero: got %b want 0010",
                     {z_phy_resetn, z_scl, z_sda, z_done});
        end
        resetn = 1'b1;
        e0 = cyc + 1;
        base = rise_cnt;
        for (int k = 0; k <= 15; k++) begin
            tick();
            n_checks++;
            if (phy_resetn !== (k >= 10)) begin
                n_fail++;
                $display("FAIL phy_resetn_release k=%0d: got %b want %b", k, phy_resetn, k >= 10);
            end
            n_checks++;
            if ({mdio_scl, mdio_sda, phy_init_done} !== 3'b010) begin
                n_fail++;
                $display("FAIL idle_before_s0 k=%0d: got %b want 010", k,
                         {mdio_scl, mdio_sda, phy_init_done});
            end
            n_checks++;
            if (z_done !== (k >= 15)) begin
                n_fail++;
                $display("FAIL zero_writes_done k=%0d: got %b want %b", k, z_done, k >= 15);
            end
        end
    endtask

    task automatic test_frames();
        int t;
        int bad;
        t = -1;
        for (int i = 0; i < 700 && t < 0; i++) begin
            tick();
            if (phy_init_done === 1'b1) t = cyc;
        end
        n_checks++;
        if (t != e0 + 535) begin
            n_fail++;
            $display("FAIL done_time: got %0d want %0d", t - e0, 535);
        end
        tick();
        n_checks++;
        if (rise_cnt - base != 128) begin
            n_fail++;
            $display("FAIL mdc_rise_count: got %0d want 128", rise_cnt - base);
        end
        n_checks++;
        if (grab(base) !== f0_exp) begin
            n_fail++;
            $display("FAIL frame0: got %h want %h", grab(base), f0_exp);
        end
        n_checks++;
        if (grab(base + 64) !== f1_exp) begin
            n_fail++;
            $display("FAIL frame1: got %h want %h", grab(base + 64), f1_exp);
        end
        n_checks++;
        if (rise_cyc[base] != e0 + 17) begin
            n_fail++;
            $display("FAIL first_rise: got %0d want 17", rise_cyc[base] - e0);
        end
        n_checks++;
        if (rise_cyc[base + 64] != e0 + 277) begin
            n_fail++;
            $display("FAIL frame1_first_rise: got %0d want 277", rise_cyc[base + 64] - e0);
        end
        bad = 0;
        for (int i = 0; i < 127; i++) begin
            if (i != 63 && rise_cyc[base+i+1] - rise_cyc[base+i] != 4) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL bit_period: got %0d bad periods want 0", bad);
        end
        repeat (5) tick();
        n_checks++;
        if (phy_init_done !== 1'b1) begin
            n_fail++;
            $display("FAIL done_sticky: got %b want 1", phy_init_done);
        end
    endtask

    task automatic test_mid_frame_reset();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        e0 = cyc + 1;
        base = rise_cnt;
        while (cyc < e0 + 176) tick();
        n_checks++;
        if (rise_cnt - base != 40) begin
            n_fail++;
            $display("FAIL rises_before_bit40: got %0d want 40", rise_cnt - base);
        end
        resetn = 1'b0;  // sampled at e0+177, inside bit 40
        tick();
        n_checks++;
        if ({phy_resetn, mdio_scl, mdio_sda, phy_init_done} !== 4'b0010) begin
            n_fail++;
            $display("FAIL mid_frame_reset_values: got %b want 0010",
                     {phy_resetn, mdio_scl, mdio_sda, phy_init_done});
        end
        resetn = 1'b1;
        e0 = cyc + 1;
        base = rise_cnt;
        while (cyc < e0 + 9) tick();
        n_checks++;
        if (phy_resetn !== 1'b0) begin
            n_fail++;
            $display("FAIL rerun_hold_end: got %b want 0", phy_resetn);
        end
        tick();
        n_checks++;
        if (phy_resetn !== 1'b1) begin
            n_fail++;
            $display("FAIL rerun_release: got %b want 1", phy_resetn);
        end
        while (cyc < e0 + 271) tick();
        n_checks++;
        if (rise_cnt - base != 64 || grab(base) !== f0_exp || rise_cyc[base] != e0 + 17) begin
            n_fail++;
            $display("FAIL rerun_frame0: got %0d rises %h first %0d want 64 rises %h first 17",
                     rise_cnt - base, grab(base), rise_cyc[base] - e0, f0_exp);
        end
    endtask

    task automatic test_restart();
        int t;
        t = -1;
        for (int i = 0; i < 700 && t < 0; i++) begin
            tick();
            if (phy_init_done === 1'b1) t = cyc;
        end
        n_checks++;
        if (t < 0) begin
            n_fail++;
            $display("FAIL done_before_restart: got timeout want done");
        end
        restart = 1'b1;
        e0 = cyc + 1;
        base = rise_cnt;
        tick();
        restart = 1'b0;
        n_checks++;
        if ({phy_resetn, phy_init_done, z_done} !== 3'b000) begin
            n_fail++;
            $display("FAIL restart_effect: got %b want 000", {phy_resetn, phy_init_done, z_done});
        end
        while (cyc < e0 + 9) tick();
        n_checks++;
        if (phy_resetn !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_hold_end: got %b want 0", phy_resetn);
        end
        tick();
        n_checks++;
        if (phy_resetn !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_release: got %b want 1", phy_resetn);
        end
        while (cyc < e0 + 12) tick();
        restart = 1'b1;  // sampled at e0+13, during SETTLE: must be ignored
        tick();
        restart = 1'b0;
        while (cyc < e0 + 14) tick();
        n_checks++;
        if (z_done !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_zero_early: got %b want 0", z_done);
        end
        tick();
        n_checks++;
        if (z_done !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_zero_done: got %b want 1", z_done);
        end
        test_frames();
    endtask

    initial begin
        f0_exp = {32'hFFFF_FFFF, 2'b01, 2'b01, 5'h01, 5'h1C, 2'b10, 16'h8C00};
        f1_exp = {32'hFFFF_FFFF, 2'b01, 2'b01, 5'h01, 5'h18, 2'b10, 16'hF1E7};
        test_reset();
        test_frames();
        test_mid_frame_reset();
        test_restart();
        n_checks++;
        if (z_rise_cnt != 0) begin
            n_fail++;
            $display("FAIL zero_writes_no_mdc: got %0d rises want 0", z_rise_cnt);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
